decode_queue_stage: RTL

Registered decode stage between fetch and EX, parametrised in queue depth and ISA mode.
- Buffers fetched (pc, instr) pairs in a DEPTH-entry FIFO.
- Decodes the FIFO head into the full control bundle (EX/MEM/WB fields), adding RV32M and illegal-instruction detection.
- Presents the result from an output register with valid/ready flow control.
- Supports a synchronous pipeline flush for branch/jump redirect.

---
 rtl/decode_queue_stage_pkg.sv | 226 ++++++++++++++++++++++
 rtl/decode_queue_stage_fifo.sv | 50 +++++
 rtl/decode_queue_stage.sv | 76 +++++++
 3 files changed

// File: rtl/decode_queue_stage_pkg.sv
// Decode types: opcodes, control selects, the ctrl_t bundle and the decode function.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package decode_queue_stage_pkg;

  typedef enum logic [6:0] {
    OPCODE_LOAD           = 7'b0000011,
    OPCODE_MISC_MEM       = 7'b0001111,
    OPCODE_ARITHMETIC_IMM = 7'b0010011,
    OPCODE_AUIPC          = 7'b0010111,
    OPCODE_STORE          = 7'b0100011,
    OPCODE_ARITHMETIC_REG = 7'b0110011,
    OPCODE_LUI            = 7'b0110111,
    OPCODE_BRANCH         = 7'b1100011,
    OPCODE_JALR           = 7'b1100111,
    OPCODE_JAL            = 7'b1101111
  } opcode_e;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MUL  = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
    ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
    ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU,
    ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
    ALU_OP_UNKNOWN
  } alu_op_e;

  typedef enum logic [1:0] {
    ALU_SRC1_RS1, ALU_SRC1_PC, ALU_SRC1_ZERO, ALU_SRC1_UNKNOWN
  } alu_src1_e;

  typedef enum logic [1:0] {
    ALU_SRC2_RS2, ALU_SRC2_IMM, ALU_SRC2_UNKNOWN
  } alu_src2_e;

  typedef enum logic [2:0] {
    IMM_SEL_I, IMM_SEL_S, IMM_SEL_B, IMM_SEL_U, IMM_SEL_J, IMM_SEL_UNKNOWN
  } imm_sel_e;

  // Encoded so a legal branch funct3 maps straight onto the enum value.
  typedef enum logic [2:0] {
    CMP_OP_EQ      = 3'b000,
    CMP_OP_NE      = 3'b001,
    CMP_OP_UNKNOWN = 3'b010,
    CMP_OP_LT      = 3'b100,
    CMP_OP_GE      = 3'b101,
    CMP_OP_LTU     = 3'b110,
    CMP_OP_GEU     = 3'b111
  } cmp_op_e;

  typedef enum logic [1:0] {
    WB_SRC_ALU_RESULT, WB_SRC_MEM_READ, WB_SRC_PC_PLUS4, WB_SRC_UNKNOWN
  } wb_src_e;

  typedef struct packed {
    alu_op_e    alu_op;
    alu_src1_e  alu_src1;
    alu_src2_e  alu_src2;
    imm_sel_e   imm_sel;
    cmp_op_e    cmp_op;
    wb_src_e    wb_src;
    logic       reg_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic [3:0] rmask;
    logic [3:0] wstrb;
    logic       mem_sext;
    logic       jump_en;
    logic       branch_en;
    logic       is_muldiv;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op:    ALU_OP_UNKNOWN,
    alu_src1:  ALU_SRC1_UNKNOWN,
    alu_src2:  ALU_SRC2_UNKNOWN,
    imm_sel:   IMM_SEL_UNKNOWN,
    cmp_op:    CMP_OP_UNKNOWN,
    wb_src:    WB_SRC_UNKNOWN,
    reg_wen:   1'b0,
    mem_ren:   1'b0,
    mem_wen:   1'b0,
    rmask:     4'b0000,
    wstrb:     4'b0000,
    mem_sext:  1'b0,
    jump_en:   1'b0,
    branch_en: 1'b0,
    is_muldiv: 1'b0,
    illegal:   1'b0
  };

  // alt selects SUB/SRA over ADD/SRL.
  function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_OP_UNKNOWN;
    case (f3)
      3'b000:  op = alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  op = ALU_OP_SLL;
      3'b010:  op = ALU_OP_SLT;
      3'b011:  op = ALU_OP_SLTU;
      3'b100:  op = ALU_OP_XOR;
      3'b101:  op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  op = ALU_OP_OR;
      default: op = ALU_OP_AND;
    endcase
    return op;
  endfunction

  function automatic alu_op_e mul_alu_op(input logic [2:0] f3);
    alu_op_e op;
    op = ALU_OP_UNKNOWN;
    case (f3)
      3'b000:  op = ALU_OP_MUL;
      3'b001:  op = ALU_OP_MULH;
      3'b010:  op = ALU_OP_MULHSU;
      3'b011:  op = ALU_OP_MULHU;
      3'b100:  op = ALU_OP_DIV;
      3'b101:  op = ALU_OP_DIVU;
      3'b110:  op = ALU_OP_REM;
      default: op = ALU_OP_REMU;
    endcase
    return op;
  endfunction

  // Byte lane mask for byte/half/word accesses; 11 is not a valid size.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    m = 4'b0000;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Full decode of one instruction. Anything illegal collapses to CTRL_NOP
  // with illegal set, so no side-effecting enable can leak through.
  function automatic ctrl_t decode_instr(input logic [31:0] instr, input logic en_mul);
    ctrl_t      c;
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    c   = CTRL_NOP;
    bad = 1'b0;
    f3  = instr[14:12];
    f7  = instr[31:25];
    case (opcode_e'(instr[6:0]))
      OPCODE_LOAD: begin
        c.alu_op = ALU_OP_ADD;  c.alu_src1 = ALU_SRC1_RS1; c.alu_src2 = ALU_SRC2_IMM;
        c.imm_sel = IMM_SEL_I;  c.wb_src = WB_SRC_MEM_READ;
        c.reg_wen = 1'b1;       c.mem_ren = 1'b1;
        c.rmask = size_mask(f3[1:0]);
        c.mem_sext = ~f3[2];
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPCODE_STORE: begin
        c.alu_op = ALU_OP_ADD;  c.alu_src1 = ALU_SRC1_RS1; c.alu_src2 = ALU_SRC2_IMM;
        c.imm_sel = IMM_SEL_S;  c.mem_wen = 1'b1;
        c.wstrb = size_mask(f3[1:0]);
        bad = (f3 >= 3'b011);
      end
      OPCODE_ARITHMETIC_IMM: begin
        c.alu_op = base_alu_op(f3, (f3 == 3'b101) && (f7 == FUNCT7_ALT));
        c.alu_src1 = ALU_SRC1_RS1; c.alu_src2 = ALU_SRC2_IMM; c.imm_sel = IMM_SEL_I;
        c.wb_src = WB_SRC_ALU_RESULT; c.reg_wen = 1'b1;
        bad = ((f3 == 3'b001) && (f7 != FUNCT7_BASE)) ||
              ((f3 == 3'b101) && (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT));
      end
      OPCODE_ARITHMETIC_REG: begin
        c.alu_src1 = ALU_SRC1_RS1; c.alu_src2 = ALU_SRC2_RS2;
        c.wb_src = WB_SRC_ALU_RESULT; c.reg_wen = 1'b1;
        case (f7)
          FUNCT7_BASE: c.alu_op = base_alu_op(f3, 1'b0);
          FUNCT7_ALT: begin
            c.alu_op = base_alu_op(f3, 1'b1);
            bad = (f3 != 3'b000) && (f3 != 3'b101);
          end
          FUNCT7_MUL: begin
            c.alu_op = mul_alu_op(f3);
            c.is_muldiv = 1'b1;
            bad = ~en_mul;
          end
          default: bad = 1'b1;
        endcase
      end
      OPCODE_BRANCH: begin
        c.alu_op = ALU_OP_ADD;  c.alu_src1 = ALU_SRC1_PC; c.alu_src2 = ALU_SRC2_IMM;
        c.imm_sel = IMM_SEL_B;  c.branch_en = 1'b1;
        c.cmp_op = cmp_op_e'(f3);
        bad = (f3[2:1] == 2'b01);
      end
      OPCODE_JAL: begin
        c.alu_op = ALU_OP_ADD;  c.alu_src1 = ALU_SRC1_PC; c.alu_src2 = ALU_SRC2_IMM;
        c.imm_sel = IMM_SEL_J;  c.wb_src = WB_SRC_PC_PLUS4;
        c.reg_wen = 1'b1;       c.jump_en = 1'b1;
      end
      OPCODE_JALR: begin
        c.alu_op = ALU_OP_ADD;  c.alu_src1 = ALU_SRC1_RS1; c.alu_src2 = ALU_SRC2_IMM;
        c.imm_sel = IMM_SEL_I;  c.wb_src = WB_SRC_PC_PLUS4;
        c.reg_wen = 1'b1;       c.jump_en = 1'b1;
        bad = (f3 != 3'b000);
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        c.alu_op = ALU_OP_ADD;
        c.alu_src1 = (instr[5]) ? ALU_SRC1_ZERO : ALU_SRC1_PC;
        c.alu_src2 = ALU_SRC2_IMM; c.imm_sel = IMM_SEL_U;
        c.wb_src = WB_SRC_ALU_RESULT; c.reg_wen = 1'b1;
      end
      // Fences have no effect on an in-order core: pass through as a bubble.
      OPCODE_MISC_MEM: c = CTRL_NOP;
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c = CTRL_NOP;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/decode_queue_stage_fifo.sv
// DEPTH-entry FIFO of {pc, instr} with registered count; flush empties it.
// Latency: written entry is visible at the head the cycle after the push.
// Backpressure: caller must only push while count < DEPTH and only pop while count > 0.
module decode_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage: queue fetched (pc, instr), decode the head into ctrl_t, register it for EX.
// Latency: instruction accepted at edge N is presented with out_valid_o after edge N+1.
// Backpressure: ready_o while registered count < DEPTH; output holds while !out_ready_i.
module decode_queue_stage
  import decode_queue_stage_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter bit EN_MUL = 1'b0,
  parameter int XLEN   = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [31:0]              out_instr_o,
  output ctrl_t                    out_ctrl_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      count;
  logic [XLEN+31:0]   head;
  logic               push;
  logic               load;
  ctrl_t              head_ctrl;

  // Ready looks only at the registered count, so a pop this cycle does not
  // open a slot until the next one; this keeps ready_o off the out_ready_i path.
  assign ready_o = (count < CW'(DEPTH));
  assign push    = valid_i && ready_o && !flush_i;
  assign load    = (count != '0) && (!out_valid_o || out_ready_i) && !flush_i;

  decode_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + 32)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (push),
    .pop   (load),
    .wdata ({pc_i, instr_i}),
    .rdata (head),
    .count (count)
  );

  assign head_ctrl   = decode_instr(head[31:0], EN_MUL);
  assign occupancy_o = count;

  // Output register: flush wins, then load from the head, else drain on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_pc_o    <= '0;
      out_instr_o <= '0;
      out_ctrl_o  <= CTRL_NOP;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (load) begin
      out_valid_o <= 1'b1;
      out_pc_o    <= head[XLEN+31:32];
      out_instr_o <= head[31:0];
      out_ctrl_o  <= head_ctrl;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
